// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin multi-channel front end for one cache port with fixed-latency read return routing.
// Define CACHE_ARB_STATS_EN to add the per-channel grant_cnt accept counters.
module cache_port_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int WORD_W      = 8,
    parameter int ADDR_W      = 32,
    parameter int CAS_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [2*NUM_CH-1:0]        req_op,
    input  logic [ADDR_W*NUM_CH-1:0]   req_addr,
    input  logic [WORD_W*NUM_CH-1:0]   req_wdata,
    output logic [NUM_CH-1:0]          rsp_valid,
    output logic [WORD_W-1:0]          rsp_rdata,
    output logic                       c_valid,
    input  logic                       c_ready,
    output logic [1:0]                 c_op,
    output logic [ADDR_W-1:0]          c_addr,
    output logic [WORD_W-1:0]          c_wdata,
    input  logic [WORD_W-1:0]          c_rdata
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [CNT_W*NUM_CH-1:0]    grant_cnt
`endif
);

    localparam int IDW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [1:0] OP_READ = 2'b01;

    logic [IDW-1:0]    ptr_q, ptr_d, win, idx;
    logic              found, accept;
    logic [CAS_LATENCY-1:0] pv_q, pv_d;
    logic [IDW-1:0]    pid_q [CAS_LATENCY];
    logic [IDW-1:0]    pid_d [CAS_LATENCY];
    logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = IDW'((int'(ptr_q) + i) % NUM_CH);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Outputs are forced quiet while reset is held, even if masters keep requesting.
    assign c_valid   = reset_n & (|req_valid);
    assign accept    = c_valid & c_ready;
    assign c_op      = c_valid ? req_op[int'(win)*2 +: 2] : '0;
    assign c_addr    = c_valid ? req_addr[int'(win)*ADDR_W +: ADDR_W] : '0;
    assign c_wdata   = c_valid ? req_wdata[int'(win)*WORD_W +: WORD_W] : '0;
    assign req_ready = accept ? (NUM_CH'(1) << win) : '0;

    always_comb begin
        ptr_d    = accept ? ((win == IDW'(NUM_CH - 1)) ? '0 : win + 1'b1) : ptr_q;
        pv_d[0]  = accept & (c_op == OP_READ);
        pid_d[0] = win;
        for (int s = 1; s < CAS_LATENCY; s++) begin
            pv_d[s]  = pv_q[s-1];
            pid_d[s] = pid_q[s-1];
        end
        rsp_valid_d = pv_q[CAS_LATENCY-1] ? (NUM_CH'(1) << pid_q[CAS_LATENCY-1]) : '0;
        rsp_rdata_d = pv_q[CAS_LATENCY-1] ? c_rdata : rsp_rdata_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            pv_q        <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            for (int s = 0; s < CAS_LATENCY; s++) pid_q[s] <= '0;
        end else begin
            ptr_q       <= ptr_d;
            pv_q        <= pv_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            for (int s = 0; s < CAS_LATENCY; s++) pid_q[s] <= pid_d[s];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef CACHE_ARB_STATS_EN
    logic [CNT_W*NUM_CH-1:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int i = 0; i < NUM_CH; i++)
            grant_cnt_d[i*CNT_W +: CNT_W] = grant_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(req_ready[i]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) grant_cnt_q <= '0;
        else          grant_cnt_q <= grant_cnt_d;
    end

    assign grant_cnt = grant_cnt_q;
`else
    // Statistics disabled: no counter state exists in this build.
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: directed checks of arbitration, backpressure, read return timing and reset.
module tb_cache_port_arbiter;

    localparam logic [1:0] RD = 2'b01, WR = 2'b10;

    logic         clock, reset_n, c_valid, c_ready;
    logic [3:0]   req_valid, req_ready, rsp_valid;
    logic [7:0]   req_op, rsp_rdata, c_wdata, c_rdata;
    logic [127:0] req_addr;
    logic [31:0]  req_wdata, c_addr;
    logic [1:0]   c_op;
`ifdef CACHE_ARB_STATS_EN
    logic [15:0]  grant_cnt;
`endif
    int checks = 0, fails = 0;

    cache_port_arbiter #(.NUM_CH(4), .WORD_W(8), .ADDR_W(32), .CAS_LATENCY(3), .CNT_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .c_valid(c_valid), .c_ready(c_ready), .c_op(c_op),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata)
`ifdef CACHE_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        req_valid = '0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] op, input logic [31:0] addr, input logic [7:0] wd);
        req_valid[ch]        = 1'b1;
        req_op[ch*2 +: 2]    = op;
        req_addr[ch*32 +: 32] = addr;
        req_wdata[ch*8 +: 8] = wd;
    endtask

    task automatic test_reset;
        tick;
        reset_n = 1'b0;
        c_ready = 1'b1;
        c_rdata = 8'h77;
        set_ch(0, RD, 32'h40, 8'h00);
        #1;
        checks++; if (c_valid !== 1'b0) begin fails++; $display("FAIL rst_c_valid: got %b expected 0", c_valid); end
        checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
        checks++; if (c_addr !== 32'h0) begin fails++; $display("FAIL rst_c_addr: got %h expected 0", c_addr); end
        checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL rst_rsp_valid: got %b expected 0000", rsp_valid); end
        checks++; if (rsp_rdata !== 8'h00) begin fails++; $display("FAIL rst_rsp_rdata: got %h expected 00", rsp_rdata); end
        tick;
        tick;
        reset_n = 1'b1;
        tick;
        idle;
        set_ch(1, RD, 32'h44, 8'h00);
        tick;
        idle;
        set_ch(2, WR, 32'h48, 8'h99);
        reset_n = 1'b0;
        #1;
        checks++; if (c_valid !== 1'b0 || c_op !== 2'b00) begin fails++; $display("FAIL mid_rst_c: got valid=%b op=%b expected 0/00", c_valid, c_op); end
        checks++; if (c_addr !== 32'h0 || c_wdata !== 8'h00) begin fails++; $display("FAIL mid_rst_fields: got addr=%h wdata=%h expected 0/0", c_addr, c_wdata); end
        checks++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin fails++; $display("FAIL mid_rst_hs: got ready=%b rsp=%b expected 0000/0000", req_ready, rsp_valid); end
        tick;
        tick;
        idle;
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL post_rst_rsp[%0d]: got %b expected 0000", k, rsp_valid); end
        end
        checks++; if (rsp_rdata !== 8'h00) begin fails++; $display("FAIL post_rst_rdata: got %h expected 00", rsp_rdata); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_rr [5];
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        idle;
        c_ready = 1'b1;
        for (int ch = 0; ch < 4; ch++) set_ch(ch, WR, 32'h1000 + ch, 8'(ch));
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== exp_rr[k]) begin fails++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_rr[k]); end
            tick;
        end
        idle;
        set_ch(1, WR, 32'h1001, 8'h01);
        #1;
        checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL rr_ch1: got %b expected 0010", req_ready); end
        tick;
        idle;
        set_ch(0, WR, 32'h1000, 8'h00);
        set_ch(3, WR, 32'h1003, 8'h03);
        #1;
        checks++; if (req_ready !== 4'b1000 || c_addr !== 32'h1003) begin fails++; $display("FAIL rr_p2_first: got %b/%h expected 1000/00001003", req_ready, c_addr); end
        tick;
        #1;
        checks++; if (req_ready !== 4'b0001 || c_addr !== 32'h1000) begin fails++; $display("FAIL rr_p2_second: got %b/%h expected 0001/00001000", req_ready, c_addr); end
        tick;
        idle;
    endtask

    task automatic test_backpressure;
        idle;
        c_ready = 1'b0;
        set_ch(1, WR, 32'h200, 8'h21);
        set_ch(3, WR, 32'h300, 8'h31);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000 || c_valid !== 1'b1) begin fails++; $display("FAIL bp_hold[%0d]: got ready=%b valid=%b expected 0000/1", k, req_ready, c_valid); end
            checks++; if (c_addr !== 32'h200 || c_wdata !== 8'h21) begin fails++; $display("FAIL bp_stable[%0d]: got %h/%h expected 00000200/21", k, c_addr, c_wdata); end
            tick;
        end
        c_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_accept: got %b expected 0010", req_ready); end
        tick;
        req_valid[1] = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b1000 || c_addr !== 32'h300) begin fails++; $display("FAIL bp_next: got %b/%h expected 1000/00000300", req_ready, c_addr); end
        tick;
        idle;
    endtask

    task automatic test_single_read;
        idle;
        c_ready = 1'b1;
        c_rdata = 8'hFF;
        set_ch(2, RD, 32'h100, 8'h00);
        #1;
        checks++; if (req_ready !== 4'b0100 || c_op !== RD || c_addr !== 32'h100) begin fails++; $display("FAIL sr_issue: got %b/%b/%h expected 0100/01/00000100", req_ready, c_op, c_addr); end
        tick;
        idle;
        checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL sr_t1: got %b expected 0000", rsp_valid); end
        tick;
        c_rdata = 8'hC3;
        tick;
        c_rdata = 8'hA5;
        checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL sr_t3: got %b expected 0000", rsp_valid); end
        tick;
        c_rdata = 8'h3C;
        checks++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 8'hA5) begin fails++; $display("FAIL sr_t4: got %b/%h expected 0100/a5", rsp_valid, rsp_rdata); end
        tick;
        checks++; if (rsp_valid !== 4'b0000 || rsp_rdata !== 8'hA5) begin fails++; $display("FAIL sr_t5: got %b/%h expected 0000/a5", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_pipelined;
        logic [3:0] exp_v [4];
        logic [7:0] exp_d [4];
        logic [7:0] drv [4];
        exp_v = '{4'b0001, 4'b0010, 4'b0001, 4'b0000};
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h33};
        drv   = '{8'h22, 8'h33, 8'hEE, 8'hEE};
        idle;
        c_ready = 1'b1;
        c_rdata = 8'hEE;
        set_ch(0, RD, 32'h10, 8'h00);
        #1;
        checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL pl_a0: got %b expected 0001", req_ready); end
        tick;
        idle;
        set_ch(1, RD, 32'h20, 8'h00);
        #1;
        checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL pl_a1: got %b expected 0010", req_ready); end
        tick;
        idle;
        set_ch(0, RD, 32'h30, 8'h00);
        #1;
        checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL pl_a2: got %b expected 0001", req_ready); end
        tick;
        idle;
        set_ch(2, WR, 32'h40, 8'h5A);
        c_rdata = 8'h11;
        #1;
        checks++; if (req_ready !== 4'b0100 || rsp_valid !== 4'b0000) begin fails++; $display("FAIL pl_a3: got %b/%b expected 0100/0000", req_ready, rsp_valid); end
        tick;
        idle;
        for (int k = 0; k < 4; k++) begin
            c_rdata = drv[k];
            checks++; if (rsp_valid !== exp_v[k] || rsp_rdata !== exp_d[k]) begin fails++; $display("FAIL pl_rsp[%0d]: got %b/%h expected %b/%h", k, rsp_valid, rsp_rdata, exp_v[k], exp_d[k]); end
            tick;
        end
    endtask

`ifdef CACHE_ARB_STATS_EN
    task automatic test_stats;
        idle;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        c_ready = 1'b1;
        set_ch(0, WR, 32'h500, 8'h01);
        repeat (17) tick;
        idle;
        checks++; if (grant_cnt[3:0] !== 4'd1) begin fails++; $display("FAIL st_wrap: got %0d expected 1", grant_cnt[3:0]); end
        set_ch(3, WR, 32'h600, 8'h02);
        tick;
        idle;
        checks++; if (grant_cnt[15:12] !== 4'd1 || grant_cnt[3:0] !== 4'd1) begin fails++; $display("FAIL st_ch3: got %h expected 1001", grant_cnt); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL st_no_rsp[%0d]: got %b expected 0000", k, rsp_valid); end
            tick;
        end
    endtask
`endif

    initial begin
        reset_n = 1'b1;
        c_ready = 1'b0;
        c_rdata = '0;
        idle;
        test_reset;
        test_round_robin;
        test_backpressure;
        test_single_read;
        test_pipelined;
`ifdef CACHE_ARB_STATS_EN
        test_stats;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
